adbg_or1k_status_cmd: RTL and testbench
=======================================

Name: adbg_or1k_status_cmd

Overview:
- JTAG-side command front end for the OR1K CPU-control sub-module. It sits directly upstream of the CPU status/stall/reset register.
- Deserialises TDI command frames while the sub-module is selected and decodes internal-register write/select opcodes.
- Emits a single-cycle write strobe plus data to the status register.
- Serialises the status register's read-back value onto TDO during capture/shift.
- Entirely in the TCK domain.

Parameters:
- STATUS_LEN, 2, width of the CPU control/status register (bit1 = cpu reset, bit0 = stall).
- OPC_LEN, 4, opcode field width.
- CMD_LEN, 1+OPC_LEN+1+STATUS_LEN (=8), exact legal command frame length in bits.

Ports:
- tck_i  in  1  JTAG TCK, sole clock; all logic on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- module_select_i  in  1  this sub-module selected by the top-level debug module.
- capture_dr_i  in  1  TAP in Capture-DR.
- shift_dr_i  in  1  TAP in Shift-DR.
- update_dr_i  in  1  TAP in Update-DR.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out.
- ctrl_reg_i  in  STATUS_LEN  read-back value from the status register.
- ctrl_we_o  out  1  write strobe to the status register, 1 TCK wide.
- ctrl_data_o  out  STATUS_LEN  write data to the status register; valid when ctrl_we_o is high.
- reg_sel_o  out  1  currently selected internal register index.
- err_o  out  1  sticky frame/opcode error flag.

Behaviour:
- Reset (rstn_i low, async): all outputs 0; shift registers 0; bit counter 0; FSM in IDLE.
- FSM states: IDLE, SHIFT, DECODE.
  - IDLE -> SHIFT on capture_dr_i & module_select_i.
  - SHIFT -> DECODE on update_dr_i.
  - DECODE -> IDLE unconditionally on the next cycle.
  - A capture_dr_i in any state restarts SHIFT: counter cleared, out shifter reloaded.
  - module_select_i low: FSM returns to IDLE, shift_dr_i and update_dr_i are ignored, and tdo_o = 0.
- Capture (SHIFT entry):
  - out_sr loaded with ctrl_reg_i zero-extended to CMD_LEN when reg_sel_o = 0; all zeros when reg_sel_o = 1.
  - bit_cnt cleared to 0.
- Shift (state SHIFT, shift_dr_i high):
  - in_sr <= {tdi_i, in_sr[CMD_LEN-1:1]}, so the first bit ends up at LSB after CMD_LEN shifts.
  - out_sr shifts right with 0 fill.
  - bit_cnt increments and saturates at 15.
  - If capture_dr_i and shift_dr_i are high together, capture wins.
- tdo_o = out_sr[0] combinationally, gated by module_select_i. The LSB of the status value appears before the first shift edge.
- Frame layout after CMD_LEN shifts:
  - in_sr[CMD_LEN-1] = command flag (1 = command).
  - next OPC_LEN bits = opcode.
  - next bit = register index.
  - low STATUS_LEN bits = data.
- Decode (state DECODE):
  - A frame is valid only if bit_cnt == CMD_LEN and the command flag is 1.
  - Command flag 0 with bit_cnt == CMD_LEN: pure read frame, no action, err_o unchanged.
  - bit_cnt != CMD_LEN (short or long frame): no action, err_o <= 1.
  - Opcode 0x0 NOP: no action, err_o <= 0.
  - Opcode 0x9 IREG_WR:
    - If reg index = 0: ctrl_data_o <= data, ctrl_we_o <= 1 for exactly this one cycle, err_o <= 0.
    - If reg index = 1: no write, err_o <= 1.
  - Opcode 0xD IREG_SEL: reg_sel_o <= reg index, err_o <= 0.
  - Any other opcode: no action, err_o <= 1.
- Latency: ctrl_we_o rises on the first tck_i edge after the edge that sampled update_dr_i high.
  - The status register therefore consumes the write one TCK later, i.e. 2 TCK after Update-DR.
- ctrl_data_o holds its last written value between strobes.
- ctrl_we_o never asserts for two consecutive cycles.
- Reset asserted mid-frame: frame discarded and all state cleared; no write strobe on reset release.

Test Plan:
- Reset, select, capture, shift 8 bits LSB-first of 0b1_1001_0_10 (data=10, idx=0, opc=9, flag=1), then update -> ctrl_we_o high exactly 1 cycle, 1 TCK after update sampled; ctrl_data_o=2'b10; err_o=0.
- ctrl_reg_i=2'b01, reg_sel_o=0, capture then 2 shifts -> tdo_o=1 before the first shift, 0 after it, 0 after the second; no write strobe if the flag bit is 0 at update.
- Shift only 7 bits of a valid IREG_WR frame, then update -> no ctrl_we_o; err_o=1. A following valid NOP frame clears err_o to 0.
- IREG_SEL with idx=1, then capture with ctrl_reg_i=2'b11 -> tdo_o stays 0 for all 8 shifts. IREG_WR with idx=1 -> no strobe, err_o=1.
- module_select_i=0 during a full valid IREG_WR frame -> no strobe, tdo_o=0, state IDLE. Opcode 0x3 frame with select high -> err_o=1.
- Assert rstn_i low after 4 shift bits, release, then pulse update -> no strobe; all outputs 0.

Source files
------------

// File: rtl/adbg_or1k_status_cmd.sv
// JTAG-side command front end for the OR1K CPU-control sub-module: deserialises
// command frames, decodes internal-register writes/selects and serialises status.
module adbg_or1k_status_cmd #(
  parameter int STATUS_LEN = 2,
  parameter int OPC_LEN    = 4,
  parameter int CMD_LEN    = 1 + OPC_LEN + 1 + STATUS_LEN
) (
  input  logic                  tck_i,
  input  logic                  rstn_i,
  input  logic                  module_select_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  input  logic [STATUS_LEN-1:0] ctrl_reg_i,
  output logic                  ctrl_we_o,
  output logic [STATUS_LEN-1:0] ctrl_data_o,
  output logic                  reg_sel_o,
  output logic                  err_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(CMD_LEN);

  localparam logic [OPC_LEN-1:0] OPC_NOP      = OPC_LEN'(0);
  localparam logic [OPC_LEN-1:0] OPC_IREG_WR  = OPC_LEN'(9);
  localparam logic [OPC_LEN-1:0] OPC_IREG_SEL = OPC_LEN'(13);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CMD_LEN-1:0]      in_sr_q, in_sr_d;
  logic [CMD_LEN-1:0]      out_sr_q, out_sr_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    ctrl_we_q, ctrl_we_d;
  logic [STATUS_LEN-1:0]   ctrl_data_q, ctrl_data_d;
  logic                    reg_sel_q, reg_sel_d;
  logic                    err_q, err_d;

  logic                    cmd_flag;
  logic [OPC_LEN-1:0]      opcode;
  logic                    reg_idx;
  logic [STATUS_LEN-1:0]   wr_data;

  assign cmd_flag = in_sr_q[CMD_LEN-1];
  assign opcode   = in_sr_q[CMD_LEN-2 -: OPC_LEN];
  assign reg_idx  = in_sr_q[STATUS_LEN];
  assign wr_data  = in_sr_q[STATUS_LEN-1:0];

  always_comb begin
    state_d     = state_q;
    in_sr_d     = in_sr_q;
    out_sr_d    = out_sr_q;
    bit_cnt_d   = bit_cnt_q;
    ctrl_we_d   = 1'b0;
    ctrl_data_d = ctrl_data_q;
    reg_sel_d   = reg_sel_q;
    err_d       = err_q;

    if (!module_select_i) begin
      state_d = IDLE;
    end else if (capture_dr_i) begin
      // Only register 0 has a readable value; other selections read back zeros.
      state_d   = SHIFT;
      bit_cnt_d = '0;
      out_sr_d  = reg_sel_q ? '0 : {{(CMD_LEN-STATUS_LEN){1'b0}}, ctrl_reg_i};
    end else begin
      case (state_q)
        SHIFT: begin
          if (update_dr_i) begin
            state_d = DECODE;
          end else if (shift_dr_i) begin
            in_sr_d  = {tdi_i, in_sr_q[CMD_LEN-1:1]};
            out_sr_d = {1'b0, out_sr_q[CMD_LEN-1:1]};
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        DECODE: begin
          state_d = IDLE;
          if (bit_cnt_q != FRAME_CNT) begin
            err_d = 1'b1;
          end else if (cmd_flag) begin
            // A frame with the command flag clear is a pure read and leaves err alone.
            case (opcode)
              OPC_NOP: err_d = 1'b0;
              OPC_IREG_WR: begin
                if (!reg_idx) begin
                  ctrl_we_d   = 1'b1;
                  ctrl_data_d = wr_data;
                  err_d       = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              OPC_IREG_SEL: begin
                reg_sel_d = reg_idx;
                err_d     = 1'b0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge tck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      bit_cnt_q   <= '0;
      ctrl_we_q   <= 1'b0;
      ctrl_data_q <= '0;
      reg_sel_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ctrl_we_q   <= ctrl_we_d;
      ctrl_data_q <= ctrl_data_d;
      reg_sel_q   <= reg_sel_d;
      err_q       <= err_d;
    end
  end

  assign tdo_o       = out_sr_q[0] & module_select_i;
  assign ctrl_we_o   = ctrl_we_q;
  assign ctrl_data_o = ctrl_data_q;
  assign reg_sel_o   = reg_sel_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_adbg_or1k_status_cmd.sv
// Directed self-checking bench for adbg_or1k_status_cmd: command decode,
// status serialisation, error flag and reset behaviour.
module tb_adbg_or1k_status_cmd;

  logic       tck = 1'b0;
  logic       rstn = 1'b0;
  logic       sel = 1'b0;
  logic       cap = 1'b0;
  logic       sh = 1'b0;
  logic       upd = 1'b0;
  logic       tdi = 1'b0;
  logic [1:0] ctrlReg = 2'b00;
  logic       tdo;
  logic       we;
  logic [1:0] data;
  logic       regSel;
  logic       err;

  int testsRun = 0;
  int failCount = 0;
  logic tdoAcc;

  adbg_or1k_status_cmd dut (
    .tck_i           (tck),
    .rstn_i          (rstn),
    .module_select_i (sel),
    .capture_dr_i    (cap),
    .shift_dr_i      (sh),
    .update_dr_i     (upd),
    .tdi_i           (tdi),
    .tdo_o           (tdo),
    .ctrl_reg_i      (ctrlReg),
    .ctrl_we_o       (we),
    .ctrl_data_o     (data),
    .reg_sel_o       (regSel),
    .err_o           (err)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture, shift nBits LSB-first, then update; returns right after the edge sampling update.
  task automatic applyStimulus(input logic [7:0] frame, input int nBits);
    cap = 1'b1;
    tick();
    cap = 1'b0;
    sh = 1'b1;
    for (int i = 0; i < nBits; i++) begin
      tdi = frame[i % 8];
      tick();
    end
    sh = 1'b0;
    tdi = 1'b0;
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  initial begin
    #2;
    checkOutput("rst_we", 8'(we), 8'h0);
    checkOutput("rst_data", 8'(data), 8'h0);
    checkOutput("rst_sel", 8'(regSel), 8'h0);
    checkOutput("rst_err", 8'(err), 8'h0);
    checkOutput("rst_tdo", 8'(tdo), 8'h0);
    tick();
    rstn = 1'b1;
    sel = 1'b1;
    tick();

    // Valid IREG_WR idx0 data=10
    applyStimulus(8'hCA, 8);
    checkOutput("wr_we_at_update", 8'(we), 8'h0);
    tick();
    checkOutput("wr_we_pulse", 8'(we), 8'h1);
    checkOutput("wr_data", 8'(data), 8'h2);
    checkOutput("wr_err", 8'(err), 8'h0);
    tick();
    checkOutput("wr_we_single", 8'(we), 8'h0);
    checkOutput("wr_data_hold", 8'(data), 8'h2);

    // Short frame (7 bits)
    applyStimulus(8'hCA, 7);
    tick();
    checkOutput("short_we", 8'(we), 8'h0);
    checkOutput("short_err", 8'(err), 8'h1);
    checkOutput("short_data", 8'(data), 8'h2);
    tick();

    // Read frame: status serialised, flag 0 leaves err set
    ctrlReg = 2'b01;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    checkOutput("rd_tdo0", 8'(tdo), 8'h1);
    sh = 1'b1;
    tdi = 1'b0;
    tick();
    checkOutput("rd_tdo1", 8'(tdo), 8'h0);
    tick();
    checkOutput("rd_tdo2", 8'(tdo), 8'h0);
    for (int i = 0; i < 6; i++) tick();
    sh = 1'b0;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    checkOutput("rd_we", 8'(we), 8'h0);
    checkOutput("rd_err_kept", 8'(err), 8'h1);

    // NOP clears err
    applyStimulus(8'h80, 8);
    tick();
    checkOutput("nop_err", 8'(err), 8'h0);
    checkOutput("nop_we", 8'(we), 8'h0);

    // IREG_SEL idx=1
    applyStimulus(8'hEC, 8);
    tick();
    checkOutput("isel_regsel", 8'(regSel), 8'h1);
    checkOutput("isel_err", 8'(err), 8'h0);
    ctrlReg = 2'b11;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    tdoAcc = tdo;
    sh = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tdoAcc = tdoAcc | tdo;
    end
    sh = 1'b0;
    checkOutput("isel_tdo_zero", 8'(tdoAcc), 8'h0);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();

    // IREG_WR to idx=1 is rejected
    applyStimulus(8'hCD, 8);
    tick();
    checkOutput("wr1_we", 8'(we), 8'h0);
    checkOutput("wr1_err", 8'(err), 8'h1);
    checkOutput("wr1_data", 8'(data), 8'h2);

    applyStimulus(8'hE8, 8);
    tick();
    checkOutput("isel0_regsel", 8'(regSel), 8'h0);
    checkOutput("isel0_err", 8'(err), 8'h0);

    // Deselected module ignores a full valid frame
    sel = 1'b0;
    applyStimulus(8'hC9, 8);
    checkOutput("desel_tdo", 8'(tdo), 8'h0);
    tick();
    checkOutput("desel_we", 8'(we), 8'h0);
    checkOutput("desel_data", 8'(data), 8'h2);
    sel = 1'b1;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    checkOutput("desel_idle_we", 8'(we), 8'h0);
    checkOutput("desel_idle_data", 8'(data), 8'h2);

    // Illegal opcode 0x3
    applyStimulus(8'h98, 8);
    tick();
    checkOutput("opc3_err", 8'(err), 8'h1);
    checkOutput("opc3_we", 8'(we), 8'h0);

    // Long frame: counter saturates, never equals frame length
    applyStimulus(8'h80, 8);
    tick();
    checkOutput("nop2_err", 8'(err), 8'h0);
    applyStimulus(8'hCA, 17);
    tick();
    checkOutput("long_err", 8'(err), 8'h1);
    checkOutput("long_we", 8'(we), 8'h0);

    // Reset mid-frame
    cap = 1'b1;
    tick();
    cap = 1'b0;
    sh = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = i[0];
      tick();
    end
    sh = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_data", 8'(data), 8'h0);
    checkOutput("midrst_err", 8'(err), 8'h0);
    checkOutput("midrst_tdo", 8'(tdo), 8'h0);
    tick();
    tick();
    rstn = 1'b1;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    checkOutput("postrst_we", 8'(we), 8'h0);
    checkOutput("postrst_data", 8'(data), 8'h0);
    checkOutput("postrst_sel", 8'(regSel), 8'h0);
    checkOutput("postrst_err", 8'(err), 8'h0);
    checkOutput("postrst_tdo", 8'(tdo), 8'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
